bip_datapath: RTL and testbench

Execution datapath of the BIP processor, directly downstream of the control unit. Each cycle it takes the decoded control strobes and the 11-bit instruction operand and performs the whole instruction in one clock:
- sign-extends the operand;
- reads or writes data memory;
- computes add or subtract;
- updates the accumulator.

It also keeps a sticky signed-overflow flag for the debug/status path.

---
 rtl/bip_pkg.sv | 31 +++
 rtl/bip_data_mem.sv | 26 ++
 rtl/bip_datapath.sv | 118 +++++++++++
 tb/tb_bip_datapath.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP datapath: widths, control encodings, clog2.
package bip_pkg;

  localparam int NB_BITS        = 16;
  localparam int NB_SIGX        = 11;
  localparam int DATA_MEM_DEPTH = 1024;

  // Accumulator source select
  localparam logic [1:0] SEL_A_MEM  = 2'b00;
  localparam logic [1:0] SEL_A_IMM  = 2'b01;
  localparam logic [1:0] SEL_A_ALU  = 2'b10;
  localparam logic [1:0] SEL_A_NONE = 2'b11;

  // ALU operation
  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // Ceiling log2, used to size the data memory address.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bip_data_mem.sv
// BIP data memory: combinational read, synchronous write, contents never reset.
module bip_data_mem #(
  parameter int NB_BITS = 16,
  parameter int DEPTH   = 1024,
  parameter int AW      = 10
) (
  input  logic               i_clk,
  input  logic               i_wr,
  input  logic [AW-1:0]      i_addr,
  input  logic [NB_BITS-1:0] i_data,
  output logic [NB_BITS-1:0] o_data
);

  logic [NB_BITS-1:0] mem_q [DEPTH];

  // Store the write data on the rising edge; no reset so contents survive it.
  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      mem_q[i_addr] <= i_data;
    end
  end

  // The read is asynchronous, so a same-cycle write is seen only after the edge.
  assign o_data = mem_q[i_addr];

endmodule

// File: rtl/bip_datapath.sv
// BIP execution datapath: sign extension, data memory, add/sub ALU,
// accumulator and a sticky signed-overflow flag. One instruction per clock.
module bip_datapath
  import bip_pkg::*;
#(
  parameter int NB_BITS        = bip_pkg::NB_BITS,
  parameter int NB_SIGX        = bip_pkg::NB_SIGX,
  parameter int DATA_MEM_DEPTH = bip_pkg::DATA_MEM_DEPTH
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_SIGX-1:0] i_operand,
  input  logic [1:0]         i_sel_a,
  input  logic               i_sel_b,
  input  logic               i_wr_acc,
  input  logic               i_op_code,
  input  logic               i_wr,
  input  logic               i_rd,
  output logic [NB_BITS-1:0] o_acc,
  output logic               o_overflow
);

  localparam int AW = clog2(DATA_MEM_DEPTH);

  logic [NB_BITS-1:0] acc_q, acc_d;
  logic               ovf_q, ovf_d;

  logic [NB_BITS-1:0] imm;
  logic [AW-1:0]      addr;
  logic [NB_BITS-1:0] mem_rdata;
  logic [NB_BITS-1:0] mdata;
  logic [NB_BITS-1:0] alu_b;
  logic [NB_BITS-1:0] alu_res;
  logic               alu_ovf;
  logic               mem_we;

  // Operand doubles as a sign-extended immediate and a wrapped memory address.
  assign imm  = {{(NB_BITS-NB_SIGX){i_operand[NB_SIGX-1]}}, i_operand};
  assign addr = i_operand[AW-1:0];

  // Writes are suppressed while reset is held so a mid-instruction reset
  // cannot leave a stray store behind.
  assign mem_we = i_wr & i_rst;

  bip_data_mem #(
    .NB_BITS (NB_BITS),
    .DEPTH   (DATA_MEM_DEPTH),
    .AW      (AW)
  ) u_data_mem (
    .i_clk  (i_clk),
    .i_wr   (mem_we),
    .i_addr (addr),
    .i_data (acc_q),
    .o_data (mem_rdata)
  );

  // Read gating: a disabled read yields zero rather than the stored word.
  assign mdata = i_rd ? mem_rdata : '0;
  assign alu_b = i_sel_b ? imm : mdata;

  // ALU result and signed overflow (judged from the operand and result signs).
  always_comb begin
    alu_res = acc_q;
    alu_ovf = 1'b0;
    if (i_op_code == OP_ADD) begin
      alu_res = acc_q + alu_b;
      alu_ovf = (acc_q[NB_BITS-1] == alu_b[NB_BITS-1]) &&
                (alu_res[NB_BITS-1] != acc_q[NB_BITS-1]);
    end else begin
      alu_res = acc_q - alu_b;
      alu_ovf = (acc_q[NB_BITS-1] != alu_b[NB_BITS-1]) &&
                (alu_res[NB_BITS-1] != acc_q[NB_BITS-1]);
    end
  end

  // Next accumulator and flag: loads clear the flag, ALU ops may set it.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (i_wr_acc) begin
      case (i_sel_a)
        SEL_A_MEM: begin
          acc_d = mdata;
          ovf_d = 1'b0;
        end
        SEL_A_IMM: begin
          acc_d = imm;
          ovf_d = 1'b0;
        end
        SEL_A_ALU: begin
          acc_d = alu_res;
          if (alu_ovf) begin
            ovf_d = 1'b1;
          end
        end
        default: begin
          acc_d = acc_q;
          ovf_d = ovf_q;
        end
      endcase
    end
  end

  // Accumulator and flag registers, cleared immediately on reset assertion.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_acc      = acc_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_bip_datapath.sv
// Bench for bip_datapath: arithmetic-level reference model checked every
// cycle, plus literal expectations from the hand-worked instruction sequence.
module tb_bip_datapath;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [10:0] i_operand;
  logic [1:0]  i_sel_a;
  logic        i_sel_b;
  logic        i_wr_acc;
  logic        i_op_code;
  logic        i_wr;
  logic        i_rd;
  logic [15:0] o_acc;
  logic        o_overflow;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [15:0] m_mem [1024];
  logic [15:0] m_acc;
  logic        m_ovf;
  bit          chk_en = 1'b0;

  always #5 i_clk = ~i_clk;

  bip_datapath dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_operand  (i_operand),
    .i_sel_a    (i_sel_a),
    .i_sel_b    (i_sel_b),
    .i_wr_acc   (i_wr_acc),
    .i_op_code  (i_op_code),
    .i_wr       (i_wr),
    .i_rd       (i_rd),
    .o_acc      (o_acc),
    .o_overflow (o_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("model_acc", {16'h0, o_acc}, {16'h0, m_acc});
      check("model_ovf", {31'h0, o_overflow}, {31'h0, m_ovf});
    end
  end

  // Apply one instruction for one clock and advance the model.
  task automatic instr(input logic [10:0] opnd, input logic [1:0] sa, input logic sb,
                       input logic wacc, input logic op, input logic wr, input logic rd);
    int addr, imm_v, md, bv, av, r;
    logic [15:0] nacc;
    logic        novf;
    i_operand = opnd; i_sel_a = sa; i_sel_b = sb; i_wr_acc = wacc;
    i_op_code = op; i_wr = wr; i_rd = rd;
    addr  = int'(opnd) % 1024;
    imm_v = opnd[10] ? int'(opnd) - 2048 : int'(opnd);
    md    = rd ? int'(m_mem[addr]) : 0;
    bv    = sb ? imm_v : ((md >= 32768) ? md - 65536 : md);
    av    = (int'(m_acc) >= 32768) ? int'(m_acc) - 65536 : int'(m_acc);
    r     = op ? av + bv : av - bv;
    nacc  = m_acc;
    novf  = m_ovf;
    if (wacc) begin
      if (sa == 2'b00) begin
        nacc = 16'(md); novf = 1'b0;
      end else if (sa == 2'b01) begin
        nacc = 16'(imm_v); novf = 1'b0;
      end else if (sa == 2'b10) begin
        nacc = 16'(r);
        if (r > 32767 || r < -32768) novf = 1'b1;
      end
    end
    @(posedge i_clk);
    #1;
    if (wr) m_mem[addr] = m_acc;
    m_acc = nacc;
    m_ovf = novf;
  endtask

  task automatic ldi (input logic [10:0] x); instr(x, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic ldv (input logic [10:0] a); instr(a, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); endtask
  task automatic sto (input logic [10:0] a); instr(a, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic addv(input logic [10:0] a); instr(a, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); endtask
  task automatic addi(input logic [10:0] x); instr(x, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); endtask
  task automatic subi(input logic [10:0] x); instr(x, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); endtask

  // Assert reset between edges while an add-and-store is on the inputs.
  task automatic mid_reset(input logic [10:0] opnd);
    i_operand = opnd; i_sel_a = 2'b10; i_sel_b = 1'b0; i_wr_acc = 1'b1;
    i_op_code = 1'b1; i_wr = 1'b1; i_rd = 1'b1;
    #2 i_rst = 1'b0;
    #1;
    check("rst_acc", {16'h0, o_acc}, 32'h0);
    check("rst_ovf", {31'h0, o_overflow}, 32'h0);
    m_acc = 16'h0;
    m_ovf = 1'b0;
    @(posedge i_clk);
    #1;
    i_sel_a = 2'b00; i_wr_acc = 1'b0; i_op_code = 1'b0; i_wr = 1'b0; i_rd = 1'b0;
    i_rst = 1'b1;
  endtask

  initial begin
    i_rst = 1'b0; i_operand = '0; i_sel_a = 2'b00; i_sel_b = 1'b0;
    i_wr_acc = 1'b0; i_op_code = 1'b0; i_wr = 1'b0; i_rd = 1'b0;
    m_acc = 16'h0; m_ovf = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("init_acc", {16'h0, o_acc}, 32'h0);
    check("init_ovf", {31'h0, o_overflow}, 32'h0);
    i_rst = 1'b1;
    chk_en = 1'b1;

    // Immediate loads and sign extension
    ldi(11'h3FF);  check("ldi_3ff", {16'h0, o_acc}, 32'h03FF);
    ldi(11'h400);  check("ldi_400", {16'h0, o_acc}, 32'hFC00);

    // Store, load, add
    ldi(11'd5); sto(11'd3); ldi(11'd2); addv(11'd3);
    check("add_var", {16'h0, o_acc}, 32'h0007);
    ldv(11'd3);    check("ld_var", {16'h0, o_acc}, 32'h0005);

    // Subtract wrap without signed overflow
    ldi(11'd7); subi(11'd10);
    check("sub_wrap", {16'h0, o_acc}, 32'hFFFD);
    check("sub_ovf", {31'h0, o_overflow}, 32'h0);

    // Build 0x7FE0 by doubling 0x3FF five times, then overflow it
    ldi(11'h3FF);
    for (int k = 0; k < 5; k++) begin
      sto(11'd10); addv(11'd10);
    end
    check("build_7fe0", {16'h0, o_acc}, 32'h7FE0);
    sto(11'd1); addv(11'd1);
    check("ovf_acc", {16'h0, o_acc}, 32'hFFC0);
    check("ovf_set", {31'h0, o_overflow}, 32'h1);
    addi(11'd1);   check("ovf_sticky", {31'h0, o_overflow}, 32'h1);
    ldi(11'd0);    check("ovf_clear", {31'h0, o_overflow}, 32'h0);

    // Set overflow again, then reset mid-instruction; the pending store is blocked
    ldv(11'd1); addv(11'd1);
    check("ovf_set2", {31'h0, o_overflow}, 32'h1);
    mid_reset(11'd3);
    ldv(11'd3);    check("wr_blocked", {16'h0, o_acc}, 32'h0005);

    // Build 0x1234, then store via alias 0x401 while loading address 1
    ldi(11'h3FF); sto(11'd20); addv(11'd20); addv(11'd20); addv(11'd20); addi(11'h238);
    check("build_1234", {16'h0, o_acc}, 32'h1234);
    instr(11'h401, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("same_cyc_old", {16'h0, o_acc}, 32'h7FE0);
    ldv(11'd1);    check("same_cyc_new", {16'h0, o_acc}, 32'h1234);

    // Halt for ten cycles, memory and accumulator unchanged
    for (int k = 0; k < 10; k++) instr(11'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("halt_acc", {16'h0, o_acc}, 32'h1234);
    ldv(11'd3);    check("halt_mem", {16'h0, o_acc}, 32'h0005);

    // Gated read
    instr(11'd3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rd_gated", {16'h0, o_acc}, 32'h0000);

    @(negedge i_clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
